// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory stage of the pipeline.
//
// Takes one entry per cycle from EXE. Entries without a memory operation are
// registered straight through to retire. Loads and stores run a valid/ready
// request on the data-memory port, and loads then wait for a read response.
// The stage holds EXE with stall_OUT while a memory op is in flight.
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   FREEZE              global hold: ret_entry frozen, no new request issued
//   mispredict,
//   flush_fCOM          flush: squash the in-flight entry and clear ret_entry
//   mem_entry           entry from EXE (held stable by EXE while stall_OUT=1)
//   dmem_ready          memory accepts the current request
//   dmem_rvalid/rdata   read response
//   dmem_req/we/addr/
//   dmem_wdata          request to memory (word aligned address)
//   stall_OUT           hold request to EXE
//   ret_entry           entry to retire: {Dst, wbData, mem_entry[255:0]}
//   do_writeback1_MEM,
//   writeRegister1_MEM,
//   Data1_MEM           bypass taken from the registered ret_entry
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int MEM_ENTRY_SIZE = 320,
  parameter int RET_ENTRY_SIZE = 320
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      FREEZE,
  input  logic                      mispredict,
  input  logic                      flush_fCOM,
  input  logic [MEM_ENTRY_SIZE-1:0] mem_entry,
  input  logic                      dmem_ready,
  input  logic                      dmem_rvalid,
  input  logic [31:0]               dmem_rdata,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [31:0]               dmem_addr,
  output logic [31:0]               dmem_wdata,
  output logic                      stall_OUT,
  output logic [RET_ENTRY_SIZE-1:0] ret_entry,
  output logic                      do_writeback1_MEM,
  output logic [5:0]                writeRegister1_MEM,
  output logic [31:0]               Data1_MEM
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DRAIN} state_t;

  state_t                    state_reg, state_next;
  logic [RET_ENTRY_SIZE-1:0] ret_entry_reg, ret_entry_next;
  // Result of a memory op that finished while FREEZE was high.
  logic                      done_valid_reg, done_valid_next;
  logic [RET_ENTRY_SIZE-1:0] done_entry_reg, done_entry_next;

  // Entry field decode
  logic        is_load, is_store, mem_op, mem_to_reg, flush;
  logic [31:0] alu_result, store_data;
  logic [RET_ENTRY_SIZE-1:0] pass_entry, load_entry;

  assign is_load    = mem_entry[139];
  assign is_store   = mem_entry[138];
  assign mem_to_reg = mem_entry[137];
  assign mem_op     = is_load | is_store;
  assign alu_result = mem_entry[223:192];
  assign store_data = mem_entry[287:256];
  assign flush      = mispredict | flush_fCOM;

  assign pass_entry = {mem_entry[319:288], alu_result, mem_entry[255:0]};
  assign load_entry = {mem_entry[319:288], (mem_to_reg ? dmem_rdata : alu_result),
                       mem_entry[255:0]};

  // IDLE issues the request in the same cycle the memory op shows up, so the
  // request can be accepted without spending a cycle in REQ. A squashed entry
  // never issues, and nothing new issues while a frozen result is parked.
  logic issue;
  logic req_active;

  assign issue      = (state_reg == IDLE) && !done_valid_reg && mem_op && !FREEZE && !flush;
  assign req_active = !RESET && ((state_reg == REQ) || issue);

  // ---------------------------------------------------------------------------
  // State register (plus the retire/parking datapath registers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= IDLE;
      ret_entry_reg  <= '0;
      done_valid_reg <= 1'b0;
      done_entry_reg <= '0;
    end else begin
      state_reg      <= state_next;
      ret_entry_reg  <= ret_entry_next;
      done_valid_reg <= done_valid_next;
      done_entry_reg <= done_entry_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (issue) begin
          if (dmem_ready) state_next = is_load ? WAIT_RD : IDLE;
          else            state_next = REQ;
        end
      end
      REQ: begin
        // The request stays up through a flush; if it is accepted anyway a
        // store is simply committed, while an accepted load still owes a
        // response and must be drained.
        if (dmem_ready) begin
          if (is_load) state_next = flush ? DRAIN : WAIT_RD;
          else         state_next = IDLE;
        end else if (flush) begin
          state_next = IDLE;
        end
      end
      WAIT_RD: begin
        if (dmem_rvalid) state_next = IDLE;
        else if (flush)  state_next = DRAIN;
      end
      DRAIN: begin
        if (dmem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / completion logic
  // ---------------------------------------------------------------------------
  logic                      result_valid;  // entry is finished this cycle
  logic                      mem_result;    // ...because a memory op finished
  logic [RET_ENTRY_SIZE-1:0] result_entry;

  always_comb begin
    result_valid = 1'b0;
    mem_result   = 1'b0;
    result_entry = pass_entry;
    case (state_reg)
      IDLE: begin
        if (done_valid_reg) begin
          result_valid = 1'b1;
          result_entry = done_entry_reg;
        end else if (!mem_op) begin
          result_valid = 1'b1;
        end else if (issue && dmem_ready && !is_load) begin
          result_valid = 1'b1;
          mem_result   = 1'b1;
        end
      end
      REQ: begin
        if (dmem_ready && !is_load) begin
          result_valid = 1'b1;
          mem_result   = 1'b1;
        end
      end
      WAIT_RD: begin
        if (dmem_rvalid) begin
          result_valid = 1'b1;
          mem_result   = 1'b1;
          result_entry = load_entry;
        end
      end
      DRAIN: begin
        // The response being drained belongs to the flushed op; only
        // non-memory entries may pass meanwhile.
        if (!mem_op) result_valid = 1'b1;
      end
      default: result_valid = 1'b0;
    endcase

    dmem_req   = req_active;
    dmem_we    = req_active & is_store;
    dmem_addr  = req_active ? {alu_result[31:2], 2'b00} : 32'd0;
    dmem_wdata = req_active ? store_data : 32'd0;
    // A memory op waiting behind DRAIN must also hold EXE, otherwise it would
    // be lost; the drained op itself no longer stalls anything.
    stall_OUT  = !RESET && !flush && mem_op && !(result_valid && !FREEZE);
  end

  // Retire register and frozen-result parking
  always_comb begin
    ret_entry_next  = ret_entry_reg;
    done_valid_next = done_valid_reg;
    done_entry_next = done_entry_reg;
    if (flush) begin
      ret_entry_next  = '0;
      done_valid_next = 1'b0;
    end else if (FREEZE) begin
      if (mem_result) begin
        done_valid_next = 1'b1;
        done_entry_next = result_entry;
      end
    end else begin
      ret_entry_next  = result_valid ? result_entry : '0;
      done_valid_next = 1'b0;
    end
  end

  assign ret_entry          = ret_entry_reg;
  assign do_writeback1_MEM  = ret_entry_reg[140];
  assign writeRegister1_MEM = ret_entry_reg[179:174];
  assign Data1_MEM          = ret_entry_reg[287:256];

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// The bench plays EXE (holds an entry until it is consumed) and the data
// memory (ready/rvalid after chosen delays). Expected retire values come from
// the entry-level rule {Dst, wbData, entry[255:0]}.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic         CLK = 1'b0;
  logic         RESET, FREEZE, mispredict, flush_fCOM;
  logic [319:0] mem_entry;
  logic         dmem_ready, dmem_rvalid;
  logic [31:0]  dmem_rdata;
  logic         dmem_req, dmem_we, stall_OUT;
  logic [31:0]  dmem_addr, dmem_wdata;
  logic [319:0] ret_entry;
  logic         do_writeback1_MEM;
  logic [5:0]   writeRegister1_MEM;
  logic [31:0]  Data1_MEM;

  int checks = 0;
  int errors = 0;
  logic [319:0] exp_ret;

  mem_stage #(.MEM_ENTRY_SIZE(320), .RET_ENTRY_SIZE(320)) dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .mispredict(mispredict),
    .flush_fCOM(flush_fCOM), .mem_entry(mem_entry), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .stall_OUT(stall_OUT), .ret_entry(ret_entry),
    .do_writeback1_MEM(do_writeback1_MEM), .writeRegister1_MEM(writeRegister1_MEM),
    .Data1_MEM(Data1_MEM)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // kind: 0 = ALU, 1 = load, 2 = store
  function automatic logic [319:0] make_entry(input int kind, input logic [31:0] alu,
                                              input logic [31:0] sdata, input logic [5:0] wreg,
                                              input logic wb, input logic m2r);
    logic [319:0] e;
    for (int i = 0; i < 10; i++) e[i*32 +: 32] = $urandom;
    e[287:256] = sdata;
    e[223:192] = alu;
    e[179:174] = wreg;
    e[140]     = wb;
    e[139]     = (kind == 1);
    e[138]     = (kind == 2);
    e[137]     = m2r;
    return e;
  endfunction

  function automatic logic [319:0] ret_model(input logic [319:0] e, input logic [31:0] rd);
    logic [31:0] wb;
    wb = (e[139] && e[137]) ? rd : e[223:192];
    return {e[319:288], wb, e[255:0]};
  endfunction

  task automatic chk_ret(input string tag);
    chk({tag, "_ret"}, ret_entry, exp_ret);
    chk({tag, "_bwb"}, do_writeback1_MEM, exp_ret[140]);
    chk({tag, "_breg"}, writeRegister1_MEM, exp_ret[179:174]);
    chk({tag, "_bdata"}, Data1_MEM, exp_ret[287:256]);
  endtask

  // Present one entry and play memory until the entry is consumed.
  // FREEZE is high during cycles [frz_lo, frz_hi) and otherwise randomly.
  task automatic run_op(input string tag, input logic [319:0] e, input int rdy_dly,
                        input int rv_dly, input logic [31:0] rdata, input int frz_pct,
                        input int frz_lo, input int frz_hi);
    bit is_ld, is_st, is_mem, rv_seen, consumed, frz, avail;
    int cyc, rdy_cnt, rv_cnt, hs;
    logic [319:0] want;
    is_ld = e[139]; is_st = e[138]; is_mem = is_ld | is_st;
    want = ret_model(e, rdata);
    cyc = 0; rdy_cnt = rdy_dly; rv_cnt = -1; hs = 0; rv_seen = 0; consumed = 0;
    mem_entry = e;
    while (!consumed && cyc < 64) begin
      frz = (cyc >= frz_lo && cyc < frz_hi) || ($urandom_range(99) < frz_pct);
      FREEZE = frz;
      dmem_rvalid = 1'b0;
      dmem_rdata = $urandom;
      if (rv_cnt > 0) rv_cnt--;
      if (rv_cnt == 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata = rdata;
        rv_cnt = -1;
        rv_seen = 1;
      end
      #1;
      dmem_ready = 1'b0;
      if (dmem_req) begin
        if (rdy_cnt == 0) dmem_ready = 1'b1;
        else rdy_cnt--;
      end
      #1;
      if (dmem_req && dmem_ready) begin
        hs++;
        chk({tag, "_addr"}, dmem_addr, {e[223:194], 2'b00});
        chk({tag, "_we"}, dmem_we, is_st);
        chk({tag, "_wdata"}, dmem_wdata, e[287:256]);
        if (is_ld) rv_cnt = rv_dly;
      end
      avail = is_mem ? (is_st ? (hs > 0) : rv_seen) : 1'b1;
      consumed = avail && !frz;
      chk({tag, "_stall"}, stall_OUT, is_mem && !consumed);
      tick();
      cyc++;
      if (!frz) exp_ret = consumed ? want : '0;
      chk_ret(tag);
    end
    chk({tag, "_done"}, consumed, 1'b1);
    chk({tag, "_hs"}, hs, is_mem);
    FREEZE = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
  endtask

  initial begin
    logic [319:0] e;
    RESET = 1'b1; FREEZE = 1'b0; mispredict = 1'b0; flush_fCOM = 1'b0;
    mem_entry = '0; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    exp_ret = '0;
    @(negedge CLK);
    tick(); tick();
    chk("rst_ret", ret_entry, 320'd0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_stall", stall_OUT, 1'b0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_byp", {do_writeback1_MEM, writeRegister1_MEM, Data1_MEM}, 39'd0);
    RESET = 1'b0;
    tick();
    chk_ret("idle");

    // ALU pass-through with bypass
    e = make_entry(0, 32'h0000_1234, $urandom, 6'd5, 1'b1, 1'b0);
    run_op("alu", e, 0, 1, 32'd0, 0, 0, 0);
    chk("alu_data1", Data1_MEM, 32'h0000_1234);
    chk("alu_reg1", writeRegister1_MEM, 6'd5);

    // Load: ready after 2 cycles, response 3 cycles later
    e = make_entry(1, 32'h0000_0100, $urandom, 6'd7, 1'b1, 1'b1);
    run_op("load", e, 2, 3, 32'hDEAD_BEEF, 0, 0, 0);
    chk("load_data1", ret_entry[287:256], 32'hDEAD_BEEF);

    // Store to unaligned address, ready immediately
    e = make_entry(2, 32'h0000_0203, 32'h0000_CAFE, 6'd3, 1'b0, 1'b0);
    run_op("store", e, 0, 1, 32'd0, 0, 0, 0);

    // Load completing under FREEZE
    e = make_entry(1, 32'h0000_0440, $urandom, 6'd11, 1'b1, 1'b1);
    run_op("frzld", e, 0, 1, 32'hA5A5_0028, 0, 1, 5);

    // Mispredict while waiting for read data, then the stray response
    e = make_entry(1, 32'h0000_0080, $urandom, 6'd12, 1'b1, 1'b1);
    mem_entry = e;
    #1 dmem_ready = dmem_req;
    chk("mp_req", dmem_req, 1'b1);
    tick();
    dmem_ready = 1'b0;
    exp_ret = '0;
    chk_ret("mp_wait");
    mispredict = 1'b1; mem_entry = '0;
    #1 chk("mp_stall", stall_OUT, 1'b0);
    tick();
    chk_ret("mp_flush");
    mispredict = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0055;
    #1 chk("mp_dreq", dmem_req, 1'b0);
    tick();
    dmem_rvalid = 1'b0;
    chk_ret("mp_drain");
    e = make_entry(0, 32'h0000_0777, $urandom, 6'd13, 1'b1, 1'b0);
    run_op("mp_alu", e, 0, 1, 32'd0, 0, 0, 0);
    e = make_entry(1, 32'h0000_0090, $urandom, 6'd14, 1'b1, 1'b1);
    run_op("mp_ld", e, 1, 2, 32'h1357_9BDF, 0, 0, 0);

    // flush_fCOM while a store is held in REQ; memory accepts in that cycle
    e = make_entry(2, 32'h0000_0600, 32'h0000_BEEF, 6'd15, 1'b0, 1'b0);
    mem_entry = e;
    tick();
    exp_ret = '0;
    chk_ret("fl_req");
    flush_fCOM = 1'b1; dmem_ready = 1'b1;
    #1 chk("fl_hs", dmem_req, 1'b1);
    tick();
    flush_fCOM = 1'b0; dmem_ready = 1'b0; mem_entry = '0;
    chk_ret("fl_ret");
    e = make_entry(0, 32'h0000_0888, $urandom, 6'd16, 1'b1, 1'b0);
    run_op("fl_alu", e, 0, 1, 32'd0, 0, 0, 0);

    // RESET while a load sits in REQ
    e = make_entry(1, 32'h0000_0300, $urandom, 6'd9, 1'b1, 1'b1);
    mem_entry = e;
    tick();
    chk("rq_req", dmem_req, 1'b1);
    RESET = 1'b1;
    tick();
    exp_ret = '0;
    chk_ret("rq");
    chk("rq_dreq", dmem_req, 1'b0);
    chk("rq_we", dmem_we, 1'b0);
    chk("rq_addr", dmem_addr, 32'd0);
    chk("rq_wdata", dmem_wdata, 32'd0);
    chk("rq_stall", stall_OUT, 1'b0);
    RESET = 1'b0; mem_entry = '0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
    tick();
    dmem_rvalid = 1'b0;
    chk_ret("rq_stray");
    e = make_entry(1, 32'h0000_0304, $urandom, 6'd10, 1'b1, 1'b1);
    run_op("rq_ld", e, 0, 2, 32'h2468_ACE0, 0, 0, 0);

    // Randomized mix of ALU, load and store entries with random freezes
    for (int i = 0; i < 150; i++) begin
      e = make_entry($urandom_range(2), $urandom, $urandom, 6'($urandom_range(63)),
                     1'($urandom_range(1)), 1'($urandom_range(1)));
      run_op("rnd", e, $urandom_range(3), $urandom_range(3, 1), $urandom,
             (i % 2 == 1) ? 25 : 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
